// File: rtl/regfile_pkg.sv
// Shared types and default widths for the cleared register file.
// Optional same-cycle forwarding is enabled by the REGFILE_BYPASS_EN macro.
package regfile_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 4;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

endpackage

// File: rtl/regfile_clear_fsm.sv
// Post-reset clear sequencer: walks every register index once, writing zero,
// then parks in READY until the next reset.
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    state_e            state_q;
    logic [ADDR_W-1:0] clr_idx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR;
            clr_idx_q <= '0;
        end else begin
            case (state_q)
                CLEAR: begin
                    clr_idx_q <= clr_idx_q + 1'b1;
                    if (clr_idx_q == {ADDR_W{1'b1}}) begin
                        state_q <= READY;
                    end
                end
                READY: begin
                    state_q <= READY;
                end
                default: begin
                    state_q   <= CLEAR;
                    clr_idx_q <= '0;
                end
            endcase
        end
    end

    // rst is folded in so the file looks busy (and writes are blocked) while reset is held.
    assign busy     = rst || (state_q == CLEAR);
    assign clr_we   = !rst && (state_q == CLEAR);
    assign clr_addr = clr_idx_q;

endmodule

// File: rtl/regfile_cleared.sv
// Architectural register file: one write port, two zero-gated combinational
// read ports, hardware clear after reset. Define REGFILE_BYPASS_EN for forwarding.
module regfile_cleared
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en1,
    input  logic [ADDR_W-1:0] rd_addr1,
    output logic [DATA_W-1:0] rd_data1,
    input  logic              rd_en2,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data2,
    output logic              busy
);

    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam int NUM_RD   = 2;

    logic [DATA_W-1:0] mem_q [NUM_REGS];

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

    logic              arr_we;
    logic [ADDR_W-1:0] arr_addr;
    logic [DATA_W-1:0] arr_data;

    logic              rd_en_w   [NUM_RD];
    logic [ADDR_W-1:0] rd_addr_w [NUM_RD];
    logic [DATA_W-1:0] rd_data_w [NUM_RD];

    regfile_clear_fsm #(
        .ADDR_W (ADDR_W)
    ) u_clear_fsm (
        .clk      (clk),
        .rst      (rst),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // The sweep owns the write port while busy; user writes are dropped then.
    always_comb begin
        arr_we   = 1'b0;
        arr_addr = wr_addr;
        arr_data = wr_data;
        if (busy) begin
            arr_we   = clr_we;
            arr_addr = clr_addr;
            arr_data = '0;
        end else if (wr_en && !((ZERO_REG != 0) && (wr_addr == '0))) begin
            arr_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (arr_we) begin
            mem_q[arr_addr] <= arr_data;
        end
    end

    assign rd_en_w[0]   = rd_en1;
    assign rd_addr_w[0] = rd_addr1;
    assign rd_en_w[1]   = rd_en2;
    assign rd_addr_w[1] = rd_addr2;

    generate
        for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd_port
            always_comb begin
                rd_data_w[gi] = '0;
                if (busy || !rd_en_w[gi] || ((ZERO_REG != 0) && (rd_addr_w[gi] == '0))) begin
                    rd_data_w[gi] = '0;
`ifdef REGFILE_BYPASS_EN
                end else if (wr_en && (rd_addr_w[gi] == wr_addr)) begin
                    rd_data_w[gi] = wr_data;
`endif
                end else begin
                    rd_data_w[gi] = mem_q[rd_addr_w[gi]];
                end
            end
        end
    endgenerate

    assign rd_data1 = rd_data_w[0];
    assign rd_data2 = rd_data_w[1];

endmodule

// File: tb/tb_regfile_cleared.sv
// Self-checking bench: ZERO_REG=1 and ZERO_REG=0 instances driven in parallel,
// compared against an array-based reference model; REGFILE_BYPASS_EN aware.
module tb_regfile_cleared;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int NR = 16;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_en1, rd_en2;
    logic [AW-1:0] rd_addr1, rd_addr2;
    logic [DW-1:0] rd1_z, rd2_z, rd1_n, rd2_n;
    logic          busy_z, busy_n;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem_z [NR];
    logic [DW-1:0] mem_n [NR];
    int            busy_left = NR;
    int            n_busy;

    always #5 clk = ~clk;

    regfile_cleared #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut_z (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en1(rd_en1), .rd_addr1(rd_addr1), .rd_data1(rd1_z),
        .rd_en2(rd_en2), .rd_addr2(rd_addr2), .rd_data2(rd2_z),
        .busy(busy_z)
    );

    regfile_cleared #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(0)) dut_n (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en1(rd_en1), .rd_addr1(rd_addr1), .rd_data1(rd1_n),
        .rd_en2(rd_en2), .rd_addr2(rd_addr2), .rd_data2(rd2_n),
        .busy(busy_n)
    );

    function automatic logic exp_busy();
        return rst || (busy_left > 0);
    endfunction

    function automatic logic [DW-1:0] exp_rd(input bit zr, input logic en, input logic [AW-1:0] a);
        if (exp_busy() || !en || (zr && a == 0)) return '0;
        if (BYP && wr_en && a == wr_addr) return wr_data;
        return zr ? mem_z[a] : mem_n[a];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Sample all outputs mid-cycle against the model.
    task automatic check_all(input string tag);
        @(negedge clk);
        $display("txn %-10s rst=%0b we=%0b wa=%0d wd=%h r1=%0b/%0d r2=%0b/%0d | z:%h %h n:%h %h busy=%0b",
                 tag, rst, wr_en, wr_addr, wr_data, rd_en1, rd_addr1, rd_en2, rd_addr2,
                 rd1_z, rd2_z, rd1_n, rd2_n, busy_z);
        chk({tag, ".busy_z"}, 32'(busy_z), 32'(exp_busy()));
        chk({tag, ".busy_n"}, 32'(busy_n), 32'(exp_busy()));
        chk({tag, ".rd1_z"}, 32'(rd1_z), 32'(exp_rd(1'b1, rd_en1, rd_addr1)));
        chk({tag, ".rd2_z"}, 32'(rd2_z), 32'(exp_rd(1'b1, rd_en2, rd_addr2)));
        chk({tag, ".rd1_n"}, 32'(rd1_n), 32'(exp_rd(1'b0, rd_en1, rd_addr1)));
        chk({tag, ".rd2_n"}, 32'(rd2_n), 32'(exp_rd(1'b0, rd_en2, rd_addr2)));
    endtask

    // Advance one edge and apply the architectural effect of the current inputs.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            busy_left = NR;
            for (int i = 0; i < NR; i++) begin
                mem_z[i] = '0;
                mem_n[i] = '0;
            end
        end else if (busy_left > 0) begin
            busy_left--;
        end else if (wr_en) begin
            mem_n[wr_addr] = wr_data;
            if (wr_addr != 0) mem_z[wr_addr] = wr_data;
        end
        #1;
    endtask

    task automatic cycle(input string tag);
        check_all(tag);
        tick();
    endtask

    task automatic count_sweep(input string tag);
        n_busy = 0;
        for (int k = 0; k < 40; k++) begin
            wr_en   = (k == 1);
            wr_addr = 4'd3;
            wr_data = 16'h5555;
            check_all(tag);
            if (busy_z !== 1'b1) break;
            n_busy++;
            tick();
        end
        wr_en = 1'b0;
        chk({tag, ".busy_len"}, 32'(n_busy), 32'd16);
    endtask

    task automatic read_all_zero(input string tag);
        for (int a = 0; a < NR; a++) begin
            rd_en1 = 1'b1; rd_addr1 = AW'(a);
            rd_en2 = 1'b1; rd_addr2 = AW'(NR - 1 - a);
            check_all(tag);
            chk({tag, ".zero_z"}, 32'(rd1_z), 32'd0);
            chk({tag, ".zero_n"}, 32'(rd1_n), 32'd0);
            tick();
        end
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_en1 = 1'b1; rd_addr1 = '0; rd_en2 = 1'b1; rd_addr2 = '0;
        #1;
        cycle("reset");
        cycle("reset");
        rst = 1'b0;

        // Sweep length, with a write to r3 issued during it.
        count_sweep("sweep");
        read_all_zero("cleared");

        // Basic write/read on r5.
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'hBEEF; rd_en1 = 1'b0; rd_en2 = 1'b0;
        cycle("wr_r5");
        wr_en = 1'b0; rd_en1 = 1'b1; rd_addr1 = 4'd5; rd_en2 = 1'b1; rd_addr2 = 4'd5;
        check_all("rd_r5");
        chk("beef1", 32'(rd1_z), 32'h0000BEEF);
        chk("beef2", 32'(rd2_n), 32'h0000BEEF);
        tick();
        rd_en2 = 1'b0;
        check_all("rd_en2_off");
        chk("rd2_gated", 32'(rd2_z), 32'd0);
        tick();

        // Zero register.
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'h1234; rd_en1 = 1'b0; rd_en2 = 1'b0;
        cycle("wr_r0");
        wr_en = 1'b0; rd_en1 = 1'b1; rd_addr1 = 4'd0; rd_en2 = 1'b1; rd_addr2 = 4'd0;
        check_all("rd_r0");
        chk("r0_zero_reg", 32'(rd1_z), 32'd0);
        chk("r0_plain", 32'(rd2_n), 32'h00001234);
        tick();

        // Same-cycle read/write of r7.
        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'h0011; rd_en1 = 1'b0; rd_en2 = 1'b0;
        cycle("wr_r7_old");
        wr_data = 16'h00AA; rd_en1 = 1'b1; rd_addr1 = 4'd7; rd_en2 = 1'b1; rd_addr2 = 4'd7;
        check_all("rw_r7");
        chk("r7_same_cycle", 32'(rd1_z), BYP ? 32'h000000AA : 32'h00000011);
        tick();
        wr_en = 1'b0;
        check_all("rd_r7_new");
        chk("r7_next_cycle", 32'(rd2_n), 32'h000000AA);
        tick();

        // Randomized traffic, biased toward read/write address collisions.
        for (int t = 0; t < 200; t++) begin
            wr_en    = 1'($urandom);
            wr_addr  = AW'($urandom);
            wr_data  = DW'($urandom);
            rd_en1   = ($urandom_range(0, 7) != 0);
            rd_en2   = ($urandom_range(0, 7) != 0);
            rd_addr1 = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom);
            rd_addr2 = ($urandom_range(0, 3) == 0) ? rd_addr1 : AW'($urandom);
            cycle("random");
        end

        // Reset mid-sweep at clr_idx == 9.
        rst = 1'b1;
        cycle("rst2");
        rst = 1'b0;
        for (int k = 0; k < 9; k++) cycle("sweep_pre");
        rst = 1'b1;
        cycle("rst_mid");
        rst = 1'b0;
        count_sweep("resweep");
        read_all_zero("recleared");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_cleared.md
Name: regfile_cleared

Overview:
- Parametrised successor to the team's fixed 16-bit, two-read-port register built from bit cells.
- DATA_W-wide storage array: NUM_REGS = 2**ADDR_W entries, one write port, two read ports.
- Hardware clear sequencer sweeps every entry to zero after reset; optional hard-wired zero register.
- Sits in the decode stage as the CPU's architectural register file; replaces the tri-state bitline read scheme with zero-driven muxed read ports.

Parameters:
- DATA_W, 16, bits per register
- ADDR_W, 4, address bits; NUM_REGS = 2**ADDR_W (localparam, not overridable)
- ZERO_REG, 1, 1 = entry 0 reads as zero and ignores writes; 0 = entry 0 is ordinary

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- wr_en  input  1  write request
- wr_addr  input  ADDR_W  write address
- wr_data  input  DATA_W  write data
- rd_en1  input  1  read port 1 enable
- rd_addr1  input  ADDR_W  read port 1 address
- rd_data1  output  DATA_W  read port 1 data, combinational
- rd_en2  input  1  read port 2 enable
- rd_addr2  input  ADDR_W  read port 2 address
- rd_data2  output  DATA_W  read port 2 data, combinational
- busy  output  1  clear sweep in progress; writes ignored, reads return zero

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- FSM has two states, CLEAR and READY, plus a clear index clr_idx[ADDR_W-1:0].
- Reset:
  - Any edge with rst=1 sets state=CLEAR and clr_idx=0.
  - busy is 1 while rst is high and for NUM_REGS edges after rst falls.
  - Reset during CLEAR restarts the sweep at index 0.
- CLEAR:
  - Each non-reset edge writes 0 to reg[clr_idx] and increments clr_idx.
  - On the edge where clr_idx==NUM_REGS-1, state goes to READY. No wrap is needed; clr_idx is don't-care in READY.
- READY:
  - busy=0.
  - wr_en=1 writes wr_data to reg[wr_addr] at the edge, visible to reads in the next cycle.
  - If ZERO_REG=1 and wr_addr==0, the write is dropped.
- Writes in CLEAR (or with rst=1) are dropped silently. There is no backpressure; the upstream pipeline stalls on busy.
- Reads, each port independent:
  - rd_dataN = 0 if busy, or rd_enN=0, or (ZERO_REG=1 and rd_addrN==0).
  - Otherwise rd_dataN = reg[rd_addrN].
- Both ports may read the same address in the same cycle with identical results.
- Read/write same address, same cycle: behaviour depends on the optional feature below.
- No X may reach either read output at any time after the first reset edge.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - In READY with wr_en=1, rd_enN=1 and rd_addrN==wr_addr, rd_dataN = wr_data in the same cycle (write-before-read forwarding).
  - The zero-register rule and the busy rule take priority over forwarding.
- Undefined: rd_dataN returns the old contents; the new value appears the cycle after the write edge.

Decomposition:
- Package regfile_pkg:
  - state typedef enum {CLEAR, READY}
  - default widths DATA_W_DEF=16, ADDR_W_DEF=4
- Sub-module regfile_clear_fsm (params ADDR_W):
  - Holds state and clr_idx.
  - Outputs busy, clr_we and clr_addr.
  - The top level muxes clr_we/clr_addr/0 onto the array write port while busy.
- Read muxing and bypass logic stay in regfile_cleared.

Test Plan:
- Clear sweep: DATA_W=16, ADDR_W=4, rst high 2 cycles then low.
  - Required: busy=1 for exactly 16 edges after rst falls.
  - Required: all 16 entries read 0x0000 with rd_en=1 after busy falls.
- Basic write/read: write 0xBEEF to r5, next cycle rd_addr1=5, rd_addr2=5 → both ports read 0xBEEF. rd_en2=0 → rd_data2=0x0000.
- Zero register (ZERO_REG=1): write 0x1234 to r0 → both ports read 0x0000 for r0. Rerun with ZERO_REG=0 → reads 0x1234.
- Same-cycle read/write of r7 (old 0x0011, new 0x00AA): with REGFILE_BYPASS_EN → 0x00AA that cycle; without → 0x0011 that cycle and 0x00AA the next.
- Write during busy: wr_en=1, r3=0x5555 issued on sweep cycle 2 → dropped; r3 reads 0x0000 after READY.
- Reset mid-sweep: rst pulsed 1 cycle at clr_idx=9 → sweep restarts at 0; busy lasts a full 16 further edges after rst falls.
